tensor_dpu_sched: RTL and testbench
===================================

# tensor_dpu_sched

Round-robin scheduler that shares one HMMA tensor dot-product unit (fixed latency, one operation in flight) among `NUM_REQS` requesters, such as per-octet issue slots. It accepts 4x2/2x4/4x4 fp32 tile requests and forwards one at a time to the DPU. It records which requester owns the in-flight operation and returns the 4x4 D tile to that requester. It drives the DPU `stall` input whenever the owning requester cannot accept its result.

## Interface
Parameters:
- `NUM_REQS`, 4: number of requesters; must be ≥2.
- `LATENCY`, `LATENCY_HMMA`: DPU pipeline depth in cycles; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQS  request valid, one bit per requester.
- `req_ready`  out  NUM_REQS  request accepted this cycle.
- `req_A`  in  NUM_REQS×[3:0][1:0][31:0]  A tiles.
- `req_B`  in  NUM_REQS×[1:0][3:0][31:0]  B tiles.
- `req_C`  in  NUM_REQS×[3:0][3:0][31:0]  C tiles.
- `req_wid`  in  NUM_REQS×`NW_WIDTH`  warp id per request.
- `dpu_valid_in`  out  1  issue to DPU.
- `dpu_ready_in`  in  1  DPU can accept.
- `dpu_A`, `dpu_B`, `dpu_C`, `dpu_wid`  out  tile widths as above  granted request payload.
- `dpu_stall`  out  1  freezes the DPU pipeline.
- `dpu_valid_out`  in  1  DPU result valid.
- `dpu_D`  in  [3:0][3:0][31:0]  result tile.
- `dpu_D_wid`  in  `NW_WIDTH`  result warp id.
- `rsp_valid`  out  NUM_REQS  result valid, one-hot on the owning requester.
- `rsp_ready`  in  NUM_REQS  requester can take its result.
- `rsp_D`  out  [3:0][3:0][31:0]  result tile, broadcast to all requesters.
- `rsp_wid`  out  `NW_WIDTH`  result warp id, broadcast.
- `err`  out  1  sticky protocol-error flag.

## Operation
- FSM has two states, IDLE and BUSY. Reset state is IDLE.
- `owner` register holds the requester index of the in-flight operation.
- `lat_cnt` counter tracks cycles since issue.
- `rr_ptr` is the round-robin priority pointer. It resets to 0.
- `can_issue` = `dpu_ready_in` && (IDLE || (BUSY && `dpu_valid_out` && `rsp_ready[owner]`)).
- Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward with modulo-`NUM_REQS` wrap.
- `dpu_valid_in` = `can_issue` && any `req_valid`.
- `req_ready[g]` = `dpu_valid_in`, asserted for the granted requester g only.
- DPU payload is muxed combinationally from requester g.
- On issue:
  - `owner` ← g.
  - `rr_ptr` ← (g+1) mod `NUM_REQS`.
  - `lat_cnt` ← 0.
  - State ← BUSY.
- `rsp_valid[owner]` = BUSY && `dpu_valid_out`. `rsp_D` and `rsp_wid` pass through from the DPU.
- `dpu_stall` = BUSY && `dpu_valid_out` && !`rsp_ready[owner]`.
- Completion is a cycle with BUSY && `dpu_valid_out` && `rsp_ready[owner]`. On completion:
  - With no new issue in the same cycle, state ← IDLE.
  - With a new issue in the same cycle, state stays BUSY and the issue updates take effect.
- `lat_cnt` increments in BUSY when `dpu_stall` is low, saturating at `LATENCY`+1.
- `err` is set and held until reset in either case:
  - `dpu_valid_out` is high while IDLE.
  - `lat_cnt` reaches `LATENCY`+1.
- Requesters must hold `req_valid` and payload stable until `req_ready`. The scheduler does not check this.

## Timing
- Reset values: `req_ready`=0, `dpu_valid_in`=0, `rsp_valid`=0, `dpu_stall`=0, `err`=0.
- While `reset` is low, all of the above outputs are forced to 0.
- Issue at cycle t gives `rsp_valid` at t+`LATENCY` with no stalls. Each stall cycle adds one cycle.
- Back-to-back throughput is one operation per `LATENCY` cycles. The next issue happens in the completion cycle, with zero bubble.
- If reset is asserted mid-operation, the in-flight result is dropped and state returns to IDLE. The DPU is reset by the same `reset`.
- All outputs except registered state are combinational from inputs and state. No path goes from `req_valid` to `req_valid`.

## Configuration
- `TENSOR_SCHED_PERF_EN` defined adds three outputs, each 32 bits and wrapping:
  - `perf_issued`: count of DPU issues.
  - `perf_stall_cycles`: cycles with `dpu_stall` high.
  - `perf_wait_cycles`: cycles with any `req_valid` high and no issue.
- All three reset to 0.
- With the macro undefined, these ports and their counters are absent.

## Structure
- Package `tensor_sched_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the tile typedefs `a_tile_t`, `b_tile_t`, `c_tile_t`, `d_tile_t`;
  - the perf counter struct.
- Sub-module `tensor_rr_arb` contains the round-robin pointer and priority search. Its interface: `NUM_REQS` request bits plus an advance enable in; one-hot grant plus index out.

## Test plan
- Single request: requester 2 issues at cycle 10 with `rsp_ready` high → `rsp_valid`=4'b0100 at cycle 10+`LATENCY`, `rsp_D` equals the DPI HMMA reference, FSM returns to IDLE.
- Contention: all four requesters valid continuously → grants in order 0,1,2,3,0, spaced exactly `LATENCY` cycles apart, no bubbles.
- Backpressure: owner's `rsp_ready` low for 5 cycles → `dpu_stall` high for those 5 cycles, result held stable, no new issue, `err` stays 0.
- Completion with same-cycle issue: requester 1 waiting when owner 0 completes → `req_ready[1]` high in the completion cycle, `owner` becomes 1 on the next edge.
- Protocol error: force `dpu_valid_out` high while IDLE → `err` goes to 1 on the next edge and stays 1 until reset.
- Reset mid-operation: assert `reset` at `LATENCY`/2 after issue → all outputs read 0, after release the FSM is IDLE and `rr_ptr` is 0.

Source files
------------

// File: rtl/tensor_dpu_sched_pkg.sv
// Shared types for the tensor DPU scheduler: FSM states, tile payloads, perf counters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NW_WIDTH (warp id width), LATENCY_HMMA (default DPU depth),
//           sched_state_t, a/b/c/d tile typedefs, perf_cnt_t.
package tensor_sched_pkg;

  localparam int NW_WIDTH     = 4;
  localparam int LATENCY_HMMA = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  // fp32 tiles, row-major: [row][col][bits]
  typedef logic [3:0][1:0][31:0] a_tile_t;  // 4x2
  typedef logic [1:0][3:0][31:0] b_tile_t;  // 2x4
  typedef logic [3:0][3:0][31:0] c_tile_t;  // 4x4
  typedef logic [3:0][3:0][31:0] d_tile_t;  // 4x4

  typedef struct packed {
    logic [31:0] issued;
    logic [31:0] stall_cycles;
    logic [31:0] wait_cycles;
  } perf_cnt_t;

endpackage

// File: rtl/tensor_dpu_sched_if.sv
// Handshake bundles between requesters, the scheduler and the shared DPU.
// Latency: n/a (wires only).
// Backpressure: valid/ready on requests and responses; stall toward the DPU.
// tensor_req_if: req_valid/req_ready + A/B/C/wid payload, rsp_valid/rsp_ready + D/wid.
//   master = requester side, slave = scheduler side.
// tensor_dpu_if: dpu_valid_in/dpu_ready_in + payload, dpu_stall, dpu_valid_out + D/wid.
//   master = scheduler side, slave = DPU side.
interface tensor_req_if
  import tensor_sched_pkg::*;
#(
  parameter int NUM_REQS = 4
);
  logic    [NUM_REQS-1:0]                req_valid;
  logic    [NUM_REQS-1:0]                req_ready;
  a_tile_t [NUM_REQS-1:0]                req_A;
  b_tile_t [NUM_REQS-1:0]                req_B;
  c_tile_t [NUM_REQS-1:0]                req_C;
  logic    [NUM_REQS-1:0][NW_WIDTH-1:0]  req_wid;
  logic    [NUM_REQS-1:0]                rsp_valid;
  logic    [NUM_REQS-1:0]                rsp_ready;
  d_tile_t                               rsp_D;
  logic    [NW_WIDTH-1:0]                rsp_wid;

  modport master (
    output req_valid, req_A, req_B, req_C, req_wid, rsp_ready,
    input  req_ready, rsp_valid, rsp_D, rsp_wid
  );
  modport slave (
    input  req_valid, req_A, req_B, req_C, req_wid, rsp_ready,
    output req_ready, rsp_valid, rsp_D, rsp_wid
  );
endinterface

interface tensor_dpu_if
  import tensor_sched_pkg::*;
;
  logic                  dpu_valid_in;
  logic                  dpu_ready_in;
  a_tile_t               dpu_A;
  b_tile_t               dpu_B;
  c_tile_t               dpu_C;
  logic [NW_WIDTH-1:0]   dpu_wid;
  logic                  dpu_stall;
  logic                  dpu_valid_out;
  d_tile_t               dpu_D;
  logic [NW_WIDTH-1:0]   dpu_D_wid;

  modport master (
    output dpu_valid_in, dpu_A, dpu_B, dpu_C, dpu_wid, dpu_stall,
    input  dpu_ready_in, dpu_valid_out, dpu_D, dpu_D_wid
  );
  modport slave (
    input  dpu_valid_in, dpu_A, dpu_B, dpu_C, dpu_wid, dpu_stall,
    output dpu_ready_in, dpu_valid_out, dpu_D, dpu_D_wid
  );
endinterface

// File: rtl/tensor_dpu_sched_rr_arb.sv
// Round-robin arbiter: priority search starting at rr_ptr, pointer moves past the winner.
// Latency: grant is combinational from req and the pointer; pointer updates on advance.
// Backpressure: none; advance is asserted by the owner only when the grant is consumed.
// Ports: clk, reset (async active-low), req[NUM_REQS], advance in;
//        grant (one-hot), grant_idx, grant_vld out.
module tensor_rr_arb #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_vld
);

  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int k;
    k         = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQS) k = k - NUM_REQS;
      if (!grant_vld && req[IDX_W'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  assign grant = grant_vld ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // Pointer lands just past the winner so it has lowest priority next round.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      if (int'(grant_idx) == NUM_REQS - 1) rr_ptr <= '0;
      else                                 rr_ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tensor_dpu_sched.sv
// Shares one fixed-latency HMMA DPU (one op in flight) among NUM_REQS requesters, round-robin.
// Latency: request to DPU is combinational; result returns LATENCY cycles after issue plus stalls.
// Backpressure: owner's rsp_ready low stalls the DPU and blocks further issue.
// Ports: clk, reset (async active-low), req (tensor_req_if.slave), dpu (tensor_dpu_if.master),
//        err (sticky protocol error). TENSOR_SCHED_PERF_EN adds perf_issued,
//        perf_stall_cycles and perf_wait_cycles (32-bit, wrapping).
module tensor_dpu_sched
  import tensor_sched_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int LATENCY  = LATENCY_HMMA
) (
  input  logic         clk,
  input  logic         reset,
  tensor_req_if.slave  req,
  tensor_dpu_if.master dpu,
  output logic         err
`ifdef TENSOR_SCHED_PERF_EN
  ,
  output logic [31:0]  perf_issued,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_wait_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_REQS);
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(LATENCY + 1);

  sched_state_t        state;
  logic [IDX_W-1:0]    owner;
  logic [CNT_W-1:0]    lat_cnt;
  logic                err_q;

  logic                busy;
  logic                owner_rdy;
  logic                stall_raw;
  logic                done;
  logic                can_issue;
  logic                any_req;
  logic                issue;
  logic [NUM_REQS-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [NUM_REQS-1:0] owner_oh;

  tensor_rr_arb #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req.req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign busy      = (state == BUSY);
  assign owner_rdy = req.rsp_ready[owner];
  assign stall_raw = busy && dpu.dpu_valid_out && !owner_rdy;
  assign done      = busy && dpu.dpu_valid_out && owner_rdy;
  // Completion frees the DPU in the same cycle, so the next op can go out with no bubble.
  assign can_issue = dpu.dpu_ready_in && (!busy || done);
  assign any_req   = |req.req_valid;
  assign issue     = can_issue && any_req && grant_vld;
  assign owner_oh  = {{(NUM_REQS-1){1'b0}}, 1'b1} << owner;

  // Handshake outputs are qualified by reset so they read 0 for the whole reset window.
  assign dpu.dpu_valid_in = issue && reset;
  assign req.req_ready    = (issue && reset) ? grant : '0;
  assign req.rsp_valid    = (busy && dpu.dpu_valid_out && reset) ? owner_oh : '0;
  assign dpu.dpu_stall    = stall_raw && reset;

  assign dpu.dpu_A   = req.req_A[grant_idx];
  assign dpu.dpu_B   = req.req_B[grant_idx];
  assign dpu.dpu_C   = req.req_C[grant_idx];
  assign dpu.dpu_wid = req.req_wid[grant_idx];

  assign req.rsp_D   = dpu.dpu_D;
  assign req.rsp_wid = dpu.dpu_D_wid;

  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      lat_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      // lat_cnt freezes while the result is held by a stall and saturates past the
      // expected return time so the timeout check stays asserted.
      if (busy && !stall_raw && lat_cnt != LAT_MAX) lat_cnt <= lat_cnt + 1'b1;
      if (issue) begin
        state   <= BUSY;
        owner   <= grant_idx;
        lat_cnt <= '0;
      end else if (done) begin
        state   <= IDLE;
      end
      if ((!busy && dpu.dpu_valid_out) || (busy && lat_cnt == LAT_MAX)) err_q <= 1'b1;
    end
  end

`ifdef TENSOR_SCHED_PERF_EN
  perf_cnt_t perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      if (issue)            perf_q.issued       <= perf_q.issued + 32'd1;
      if (stall_raw)        perf_q.stall_cycles <= perf_q.stall_cycles + 32'd1;
      if (any_req && !issue) perf_q.wait_cycles <= perf_q.wait_cycles + 32'd1;
    end
  end

  assign perf_issued       = perf_q.issued;
  assign perf_stall_cycles = perf_q.stall_cycles;
  assign perf_wait_cycles  = perf_q.wait_cycles;
`endif

endmodule

// File: tb/tb_tensor_dpu_sched.sv
// Bench for tensor_dpu_sched: randomized requesters and a behavioural DPU around the DUT,
// checked cycle by cycle against a transaction-level scheduling model.
// Directed phases cover reset, single issue, contention, backpressure, errors, mid-op reset.
module tb_tensor_dpu_sched;
  import tensor_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = LATENCY_HMMA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  always #5 clk = ~clk;

  tensor_req_if #(.NUM_REQS(N)) rq ();
  tensor_dpu_if                 dp ();

`ifdef TENSOR_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall_cycles, perf_wait_cycles;
`endif

  tensor_dpu_sched #(.NUM_REQS(N), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .req   (rq.slave),
    .dpu   (dp.master),
    .err   (err)
`ifdef TENSOR_SCHED_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_wait_cycles  (perf_wait_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requesters
  bit                  pend [N];
  a_tile_t             pA   [N];
  b_tile_t             pB   [N];
  c_tile_t             pC   [N];
  logic [NW_WIDTH-1:0] pW   [N];
  int                  gen_prob  = 0;
  int                  rsp_prob  = 100;
  int                  rdy_prob  = 100;
  logic [N-1:0]        rsp_block = '0;

  // behavioural DPU
  bit                  d_busy = 0;
  int                  d_cnt  = 0;
  d_tile_t             d_D    = '0;
  logic [NW_WIDTH-1:0] d_wid  = '0;
  bit                  force_vout = 0;
  bit                  drop_res   = 0;
  bit                  err_dc     = 0;

  // scheduling model
  bit                  m_busy = 0;
  int                  m_own  = 0;
  int                  m_ptr  = 0;
  bit                  m_err  = 0;
  d_tile_t             m_expD = '0;
  logic [NW_WIDTH-1:0] m_expW = '0;

  // observations from the last cycle
  logic [N-1:0] obs_rdy, obs_rspv;
  bit           obs_vout, obs_stall, obs_err;
  d_tile_t      obs_D;
  int           glog [$];
  int           gcyc [$];
  int           last_done_own = -1;
  int           last_done_cyc = -1;
  int           stall_cnt = 0;
  int           issue_cnt = 0;

  task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic d_tile_t hmma(input a_tile_t a, input b_tile_t b, input c_tile_t c);
    d_tile_t d;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        d[i][j] = c[i][j] + a[i][0] * b[0][j] + a[i][1] * b[1][j];
    return d;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic new_req(input int r);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) begin
        pA[r][i][k] = $urandom;
        pB[r][k][i] = $urandom;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pC[r][i][j] = $urandom;
    pW[r]   = NW_WIDTH'($urandom);
    pend[r] = 1'b1;
  endtask

  // One clock: drive at negedge, check 1 time unit later, update environment after posedge.
  task automatic cycle();
    logic [N-1:0] one, e_rdy, e_rspv, rr;
    bit           e_iss, e_stall, e_done, own_rdy, vout, dpu_rdy, iss_a, e_err;
    int           g, k;
    a_tile_t      sA;
    b_tile_t      sB;
    c_tile_t      sC;
    logic [NW_WIDTH-1:0] sW;

    for (int r = 0; r < N; r++) begin
      rq.req_valid[r] = pend[r];
      rq.req_A[r]     = pA[r];
      rq.req_B[r]     = pB[r];
      rq.req_C[r]     = pC[r];
      rq.req_wid[r]   = pW[r];
      rq.rsp_ready[r] = !rsp_block[r] && ($urandom_range(99) < rsp_prob);
    end
    dp.dpu_ready_in  = ($urandom_range(99) < rdy_prob);
    dp.dpu_valid_out = (d_busy && d_cnt == 0) || force_vout;
    dp.dpu_D         = d_D;
    dp.dpu_D_wid     = d_wid;
    #1;

    one  = 1;
    vout = dp.dpu_valid_out;
    g    = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (g < 0 && pend[k]) g = k;
    end
    own_rdy = rq.rsp_ready[m_own];
    e_rspv  = '0; e_rdy = '0; e_iss = 0; e_stall = 0; e_done = 0; e_err = 0;
    if (rst_n) begin
      e_rspv  = (m_busy && vout) ? (one << m_own) : '0;
      e_stall = m_busy && vout && !own_rdy;
      e_done  = m_busy && vout && own_rdy;
      e_iss   = dp.dpu_ready_in && (!m_busy || e_done) && (g >= 0);
      e_rdy   = e_iss ? (one << g) : '0;
      e_err   = m_err;
    end

    check_val("req_ready",    rq.req_ready,    e_rdy);
    check_val("dpu_valid_in", dp.dpu_valid_in, e_iss);
    check_val("rsp_valid",    rq.rsp_valid,    e_rspv);
    check_val("dpu_stall",    dp.dpu_stall,    e_stall);
    if (!err_dc) check_val("err", err, e_err);
    if (e_iss) begin
      check_val("dpu_A",   dp.dpu_A,   pA[g]);
      check_val("dpu_B",   dp.dpu_B,   pB[g]);
      check_val("dpu_C",   dp.dpu_C,   pC[g]);
      check_val("dpu_wid", dp.dpu_wid, pW[g]);
    end
    if (e_done) begin
      check_val("rsp_D",   rq.rsp_D,   m_expD);
      check_val("rsp_wid", rq.rsp_wid, m_expW);
    end

    obs_rdy   = rq.req_ready;
    obs_rspv  = rq.rsp_valid;
    obs_vout  = vout;
    obs_stall = dp.dpu_stall;
    obs_err   = err;
    obs_D     = rq.rsp_D;
    rr        = rq.rsp_ready;
    dpu_rdy   = dp.dpu_ready_in;
    iss_a     = dp.dpu_valid_in;
    sA = dp.dpu_A; sB = dp.dpu_B; sC = dp.dpu_C; sW = dp.dpu_wid;
    if (obs_rdy != '0) begin
      glog.push_back(oh_idx(obs_rdy));
      gcyc.push_back(cyc);
    end
    if ((obs_rspv & rr) != '0) begin
      last_done_own = oh_idx(obs_rspv & rr);
      last_done_cyc = cyc;
    end
    if (obs_stall) stall_cnt++;
    if (iss_a)     issue_cnt++;

    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_err = 0;
      d_busy = 0; d_cnt = 0;
    end else begin
      if (!m_busy && vout) m_err = 1;
      if (e_iss) begin
        m_own  = g;
        m_ptr  = (g + 1) % N;
        m_busy = 1;
        m_expD = hmma(pA[g], pB[g], pC[g]);
        m_expW = pW[g];
      end else if (e_done) begin
        m_busy = 0;
      end
      if (d_busy && d_cnt == 0) begin
        if (!obs_stall) d_busy = 0;
      end else if (d_busy && !obs_stall) begin
        d_cnt--;
      end
      if (iss_a && dpu_rdy && !drop_res) begin
        d_busy = 1;
        d_cnt  = LAT - 1;
        d_D    = hmma(sA, sB, sC);
        d_wid  = sW;
      end
    end
    for (int r = 0; r < N; r++) begin
      if (obs_rdy[r]) pend[r] = 0;
      if (!pend[r] && gen_prob > 0 && $urandom_range(99) < gen_prob) new_req(r);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    for (int r = 0; r < N; r++) pend[r] = 0;
    err_dc   = 0;
    drop_res = 0;
    rst_n    = 1'b1;
    cycle();
  endtask

  initial begin
    int k;
    d_tile_t d_ref;
    for (int r = 0; r < N; r++) begin
      pend[r] = 0; pA[r] = '0; pB[r] = '0; pC[r] = '0; pW[r] = '0;
    end
    rq.req_valid = '0; rq.rsp_ready = '0;
    dp.dpu_ready_in = 1'b0; dp.dpu_valid_out = 1'b0; dp.dpu_D = '0; dp.dpu_D_wid = '0;
    @(negedge clk);

    // Reset with every requester pending: all handshake outputs must stay 0.
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) new_req(r);
    repeat (3) cycle();
    for (int r = 0; r < N; r++) pend[r] = 0;
    rst_n = 1'b1;
    repeat (6) cycle();

    // Single request from requester 2.
    glog.delete(); gcyc.delete();
    new_req(2);
    repeat (LAT + 2) cycle();
    check_val("single_grant_cnt", glog.size(), 1);
    if (glog.size() > 0) begin
      check_val("single_grant_idx", glog[0], 2);
      check_val("single_latency", last_done_cyc - gcyc[0], LAT);
    end
    check_val("single_owner", last_done_own, 2);
    new_req(3);
    cycle();
    check_val("idle_reissue", obs_rdy, 4'b1000);
    repeat (LAT + 2) cycle();

    // Contention from a fresh pointer: 0,1,2,3,0 spaced LAT apart.
    do_reset();
    glog.delete(); gcyc.delete();
    gen_prob = 100;
    for (int r = 0; r < N; r++) new_req(r);
    repeat (5 * LAT + 2) cycle();
    gen_prob = 0;
    check_val("contend_cnt_ok", glog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      check_val("contend_order", glog[i], i % N);
      if (i > 0) check_val("contend_spacing", gcyc[i] - gcyc[i-1], LAT);
    end

    // Backpressure: owner 0 holds rsp_ready low for 5 result cycles, requester 1 waits.
    do_reset();
    new_req(0); new_req(1);
    rsp_block = 4'b0001;
    cycle();
    stall_cnt = 0; issue_cnt = 0;
    k = 0;
    obs_vout = 0;
    while (!obs_vout && k < 4 * LAT) begin
      cycle();
      k++;
    end
    check_val("bp_result_seen", obs_vout, 1);
    d_ref = obs_D;
    repeat (4) begin
      cycle();
      check_val("bp_result_hold", obs_D, d_ref);
    end
    rsp_block = '0;
    cycle();
    check_val("bp_stall_cycles", stall_cnt, 5);
    check_val("bp_issue_in_done", issue_cnt, 1);
    check_val("done_issue_ready", obs_rdy, 4'b0010);
    check_val("done_rsp_valid", obs_rspv, 4'b0001);
    check_val("bp_err", obs_err, 0);
    repeat (LAT + 1) cycle();
    check_val("done_next_owner", last_done_own, 1);

    // Result valid while idle sets a sticky error.
    do_reset();
    force_vout = 1;
    cycle();
    force_vout = 0;
    check_val("idle_vout_err", err, 1);
    repeat (4) begin
      cycle();
      check_val("idle_vout_sticky", obs_err, 1);
    end
    do_reset();
    check_val("err_cleared", err, 0);

    // Reset in the middle of an operation owned by requester 2.
    new_req(2);
    cycle();
    repeat (LAT / 2 - 1) cycle();
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) if (!pend[r]) new_req(r);
    repeat (2) cycle();
    check_val("midrst_ready", obs_rdy, 0);
    check_val("midrst_rspv", obs_rspv, 0);
    rst_n = 1'b1;
    glog.delete(); gcyc.delete();
    cycle();
    check_val("midrst_ptr0", glog.size() > 0 ? glog[0] : -1, 0);
    do_reset();

    // Result never returns: timeout error.
    drop_res = 1; err_dc = 1;
    new_req(1);
    cycle();
    repeat (LAT) cycle();
    check_val("timeout_early", err, 0);
    repeat (3) cycle();
    check_val("timeout_err", err, 1);
    do_reset();

    // Randomized traffic.
    gen_prob = 40; rsp_prob = 75; rdy_prob = 85;
    repeat (2000) cycle();
    gen_prob = 0; rsp_prob = 100; rdy_prob = 100;
    repeat (6 * LAT) cycle();
    check_val("random_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
